// File: rtl/monitor_pkg.sv
// Shared constants and grant encoding for the monitor RAM slice.
// Imported by the arbiter, its bus interface and the bench.
package monitor_pkg;

    localparam int MON_RAM_ADDR_W  = 11;
    localparam int MON_DATA_W      = 8;
    localparam int MON_MAX_WAIT    = 4;
    localparam int MON_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DBG  = 2'd2
    } grant_e;

endpackage

// File: rtl/monitor_ram_arbiter_if.sv
// CPU, debug and RAM-side bus bundle of the monitor RAM arbiter.
// slave = arbiter view, master = requester/RAM view.
interface monitor_ram_arbiter_if
    import monitor_pkg::*;
#(
    parameter int ADDR_W = MON_RAM_ADDR_W,
    parameter int DATA_W = MON_DATA_W
);

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;

    logic              dbg_req;
    logic              dbg_write;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
        output cpu_ready,
        input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rvalid, dbg_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_ready,
        output dbg_req, dbg_write, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rvalid, dbg_rdata,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/monitor_ram_arbiter.sv
// Shares the monitor's single-port RAM between the CPU (fixed priority)
// and a debug/loader port that is guaranteed service after MAX_WAIT cycles.
module monitor_ram_arbiter
    import monitor_pkg::*;
#(
    parameter int ADDR_W      = MON_RAM_ADDR_W,
    parameter int DATA_W      = MON_DATA_W,
    parameter int MAX_WAIT    = MON_MAX_WAIT,
    parameter int STALL_CNT_W = MON_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    monitor_ram_arbiter_if.slave   bus,
    output logic [STALL_CNT_W-1:0] cpu_stall_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    grant_e            grant;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force_dbg;
    logic              rd_pending;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // wait_cnt saturates at WAIT_MAX, so equality is the threshold test
    always_comb begin
        force_dbg = bus.dbg_req & (wait_cnt == WAIT_MAX);
    end

    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            grant = GNT_NONE;
        end else if (force_dbg) begin
            grant = GNT_DBG;
        end else if (bus.cpu_req) begin
            grant = GNT_CPU;
        end else if (bus.dbg_req) begin
            grant = GNT_DBG;
        end
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        unique case (grant)
            GNT_CPU: begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_we    = bus.cpu_write;
            end
            GNT_DBG: begin
                bus.ram_addr  = bus.dbg_addr;
                bus.ram_wdata = bus.dbg_wdata;
                bus.ram_we    = bus.dbg_write;
            end
            default: begin
                bus.ram_addr  = '0;
                bus.ram_wdata = '0;
                bus.ram_we    = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.dbg_ack   = (grant == GNT_DBG);
        bus.cpu_ready = ~(bus.cpu_req & (grant == GNT_DBG));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!bus.dbg_req || bus.dbg_ack) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Debug read: ack in N, RAM data in N+1, rvalid in N+2
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_pending <= bus.dbg_ack & ~bus.dbg_write;
            rvalid_q   <= rd_pending;
            if (rd_pending) begin
                rdata_q <= bus.ram_rdata;
            end
        end
    end

    always_comb begin
        bus.dbg_rvalid = rvalid_q;
        bus.dbg_rdata  = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_stall_cnt <= '0;
        end else if (!bus.cpu_ready && (cpu_stall_cnt != '1)) begin
            cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_monitor_ram_arbiter.sv
// Directed bench for monitor_ram_arbiter: MAX_WAIT=4 instance with a RAM
// model, plus a MAX_WAIT=0 instance for debug-priority behaviour.
module tb_monitor_ram_arbiter;
    import monitor_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [15:0] stall_a;
    logic [15:0] stall_b;
    logic [7:0]  mem [0:2047];

    monitor_ram_arbiter_if #(.ADDR_W(11), .DATA_W(8)) a_if ();
    monitor_ram_arbiter_if #(.ADDR_W(11), .DATA_W(8)) b_if ();

    monitor_ram_arbiter #(
        .ADDR_W(11), .DATA_W(8), .MAX_WAIT(4), .STALL_CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(a_if), .cpu_stall_cnt(stall_a)
    );

    monitor_ram_arbiter #(
        .ADDR_W(11), .DATA_W(8), .MAX_WAIT(0), .STALL_CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(b_if), .cpu_stall_cnt(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after the address
    always @(posedge clk) begin
        if (a_if.ram_we) mem[a_if.ram_addr] <= a_if.ram_wdata;
        a_if.ram_rdata <= mem[a_if.ram_addr];
    end
    assign b_if.ram_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_if.cpu_req   = 1'b0;
        a_if.cpu_write = 1'b0;
        a_if.cpu_addr  = '0;
        a_if.cpu_wdata = '0;
        a_if.dbg_req   = 1'b0;
        a_if.dbg_write = 1'b0;
        a_if.dbg_addr  = '0;
        a_if.dbg_wdata = '0;
    endtask

    task automatic cpu_wr(input logic [10:0] ad, input logic [7:0] d);
        a_if.cpu_req   = 1'b1;
        a_if.cpu_write = 1'b1;
        a_if.cpu_addr  = ad;
        a_if.cpu_wdata = d;
        cyc();
    endtask

    initial begin
        logic [5:0] pc;
        logic [5:0] pd;
        logic [5:0] pr;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle_a();
        b_if.cpu_req   = 1'b0;
        b_if.cpu_write = 1'b0;
        b_if.cpu_addr  = '0;
        b_if.cpu_wdata = '0;
        b_if.dbg_req   = 1'b0;
        b_if.dbg_write = 1'b0;
        b_if.dbg_addr  = '0;
        b_if.dbg_wdata = '0;

        // Reset: requests present but grant must be NONE
        #1;
        a_if.cpu_req   = 1'b1;
        a_if.cpu_write = 1'b1;
        a_if.dbg_req   = 1'b1;
        a_if.dbg_write = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_we", 32'(a_if.ram_we), 32'd0);
        chk("rst_ack", 32'(a_if.dbg_ack), 32'd0);
        chk("rst_ready", 32'(a_if.cpu_ready), 32'd1);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_rvalid", 32'(a_if.dbg_rvalid), 32'd0);
        chk("rst_rdata", 32'(a_if.dbg_rdata), 32'd0);
        cyc();
        idle_a();
        reset = 1'b1;
        cyc();

        // CPU write $55 to $123 then read it back
        a_if.cpu_req   = 1'b1;
        a_if.cpu_write = 1'b1;
        a_if.cpu_addr  = 11'h123;
        a_if.cpu_wdata = 8'h55;
        @(negedge clk);
        chk("cw_we", 32'(a_if.ram_we), 32'd1);
        chk("cw_addr", 32'(a_if.ram_addr), 32'h123);
        chk("cw_ready", 32'(a_if.cpu_ready), 32'd1);
        cyc();
        a_if.cpu_write = 1'b0;
        @(negedge clk);
        chk("cr_we", 32'(a_if.ram_we), 32'd0);
        chk("cr_ready", 32'(a_if.cpu_ready), 32'd1);
        cyc();
        idle_a();
        @(negedge clk);
        chk("cr_rdata", 32'(a_if.ram_rdata), 32'h55);
        cyc();

        // Preload RAM through the CPU
        cpu_wr(11'h7ff, 8'ha5);
        cpu_wr(11'h000, 8'h00);
        cpu_wr(11'h001, 8'h01);
        cpu_wr(11'h002, 8'h02);
        cpu_wr(11'h003, 8'h03);
        idle_a();
        cyc();

        // Debug read of $7FF, CPU idle
        a_if.dbg_req  = 1'b1;
        a_if.dbg_addr = 11'h7ff;
        @(negedge clk);
        chk("dr_ack", 32'(a_if.dbg_ack), 32'd1);
        cyc();
        idle_a();
        @(negedge clk);
        chk("dr_rv_n1", 32'(a_if.dbg_rvalid), 32'd0);
        cyc();
        @(negedge clk);
        chk("dr_rv_n2", 32'(a_if.dbg_rvalid), 32'd1);
        chk("dr_data", 32'(a_if.dbg_rdata), 32'ha5);
        cyc();
        @(negedge clk);
        chk("dr_rv_n3", 32'(a_if.dbg_rvalid), 32'd0);
        chk("dr_hold", 32'(a_if.dbg_rdata), 32'ha5);
        cyc();

        // CPU busy every cycle, debug write forced on 5th cycle
        a_if.cpu_req   = 1'b1;
        a_if.cpu_addr  = 11'h200;
        a_if.dbg_req   = 1'b1;
        a_if.dbg_write = 1'b1;
        a_if.dbg_addr  = 11'h010;
        a_if.dbg_wdata = 8'h3c;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("fw_ack%0d", k), 32'(a_if.dbg_ack),
                (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("fw_rdy%0d", k), 32'(a_if.cpu_ready),
                (k == 5) ? 32'd0 : 32'd1);
            if (k == 5) begin
                chk("fw_we", 32'(a_if.ram_we), 32'd1);
                chk("fw_addr", 32'(a_if.ram_addr), 32'h010);
                chk("fw_wdata", 32'(a_if.ram_wdata), 32'h3c);
            end
            cyc();
        end
        a_if.dbg_req   = 1'b0;
        a_if.dbg_write = 1'b0;
        a_if.cpu_addr  = 11'h010;
        @(negedge clk);
        chk("fw_stall", 32'(stall_a), 32'd1);
        chk("fw_rdy_after", 32'(a_if.cpu_ready), 32'd1);
        cyc();
        idle_a();
        @(negedge clk);
        chk("fw_cpu_rd", 32'(a_if.ram_rdata), 32'h3c);
        cyc();

        // Four back-to-back debug reads of $000-$003
        for (int c = 0; c < 7; c++) begin
            a_if.dbg_req  = (c < 4);
            a_if.dbg_addr = 11'(c);
            @(negedge clk);
            chk($sformatf("b2b_ack%0d", c), 32'(a_if.dbg_ack),
                (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_rv%0d", c), 32'(a_if.dbg_rvalid),
                (c >= 2 && c < 6) ? 32'd1 : 32'd0);
            if (c >= 2 && c < 6)
                chk($sformatf("b2b_dat%0d", c), 32'(a_if.dbg_rdata),
                    32'(c - 2));
            cyc();
        end
        idle_a();

        // MAX_WAIT=0: debug wins whenever it requests
        pc = 6'b010111;
        pd = 6'b001110;
        pr = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            b_if.cpu_req = pc[i];
            b_if.dbg_req = pd[i];
            @(negedge clk);
            chk($sformatf("mw0_ack%0d", i), 32'(b_if.dbg_ack), 32'(pd[i]));
            chk($sformatf("mw0_rdy%0d", i), 32'(b_if.cpu_ready),
                32'(pr[i]));
            cyc();
        end
        b_if.cpu_req = 1'b0;
        b_if.dbg_req = 1'b0;
        @(negedge clk);
        chk("mw0_stall", 32'(stall_b), 32'd2);
        cyc();

        // Reset in the cycle after a debug read ack
        a_if.dbg_req  = 1'b1;
        a_if.dbg_addr = 11'h001;
        @(negedge clk);
        chk("rr_ack", 32'(a_if.dbg_ack), 32'd1);
        cyc();
        a_if.dbg_req   = 1'b0;
        a_if.cpu_req   = 1'b1;
        a_if.cpu_write = 1'b1;
        a_if.cpu_addr  = 11'h055;
        reset = 1'b0;
        @(negedge clk);
        chk("rr_we", 32'(a_if.ram_we), 32'd0);
        cyc();
        @(negedge clk);
        chk("rr_rvalid", 32'(a_if.dbg_rvalid), 32'd0);
        chk("rr_rdata", 32'(a_if.dbg_rdata), 32'd0);
        chk("rr_stall", 32'(stall_a), 32'd0);
        chk("rr_stall_b", 32'(stall_b), 32'd0);
        chk("rr_wait", 32'(dut_a.wait_cnt), 32'd0);
        chk("rr_we2", 32'(a_if.ram_we), 32'd0);
        idle_a();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("rr_rv_after", 32'(a_if.dbg_rvalid), 32'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_ram_arbiter.md
Name: monitor_ram_arbiter

Overview:
Shares the monitor's single-port 2 KB RAM ($0000-$07FF) between two requesters. The first is the monitor CPU, using the RAM decode from the monitor bus. The second is a debug/loader port (UART or host DMA) that needs to load and inspect monitor RAM while the CPU runs. The CPU has fixed priority. A wait counter guarantees that the debug port is never starved, at the cost of stalling the CPU for one cycle.

Parameters:
ADDR_W, 11, RAM address width (2048 bytes)
DATA_W, 8, data width
MAX_WAIT, 4, debug wait cycles before the CPU is forcibly stalled; 0 gives the debug port priority
STALL_CNT_W, 16, width of the CPU-stall statistics counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU addresses RAM this cycle (decoded RAM select)
cpu_write  in  1  CPU write strobe
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  low = CPU access not performed; CPU repeats it next cycle
dbg_req  in  1  debug request; req, write, addr and wdata are held stable until dbg_ack
dbg_write  in  1  debug write (1) / read (0)
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  debug request performed this cycle
dbg_rvalid  out  1  one-cycle pulse: dbg_rdata is valid
dbg_rdata  out  DATA_W  registered debug read data, held until the next read
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address
cpu_stall_cnt  out  STALL_CNT_W  saturating count of forced CPU stalls

Behaviour:
- Grant is combinational each cycle; states are GNT_NONE, GNT_CPU and GNT_DBG.
- force = dbg_req & (wait_cnt >= MAX_WAIT).
- Grant priority:
  - If force, grant DBG.
  - Else if cpu_req, grant CPU.
  - Else if dbg_req, grant DBG.
  - Else NONE.
- cpu_ready = ~(cpu_req & grant==DBG). The CPU is never stalled when it is not requesting.
- dbg_ack = (grant==DBG).
- RAM drive:
  - GNT_CPU: ram_* = cpu_*, ram_we = cpu_write.
  - GNT_DBG: ram_* = dbg_*, ram_we = dbg_write.
  - GNT_NONE: ram_addr = 0, ram_wdata = 0, ram_we = 0.
- Reset low forces grant NONE:
  - ram_we = 0, dbg_ack = 0, cpu_ready = 1.
  - On the clock edge: wait_cnt = 0, rd_pending = 0, dbg_rvalid = 0, dbg_rdata = 0, cpu_stall_cnt = 0.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Cleared when dbg_req = 0 or dbg_ack = 1.
  - Otherwise +1, saturating at MAX_WAIT.
- Debug read pipeline for an ack in cycle N:
  - rd_pending is set at the end of cycle N.
  - ram_rdata is valid in N+1 and is registered into dbg_rdata at the end of N+1.
  - dbg_rvalid is high in N+2. Read latency from ack is 2 cycles.
  - Back-to-back debug reads yield back-to-back rvalid pulses.
- Debug writes: complete in the ack cycle; no rvalid.
- CPU reads: ram_rdata in N+1 belongs to the CPU access of N, regardless of the grant in N+1. The arbiter never delays CPU read data.
- cpu_stall_cnt: +1 on each cycle with cpu_ready = 0; saturates at all-ones.
- Reset mid-read: the pending read is dropped and no rvalid is produced.
- Boundary cases:
  - dbg_req dropped before ack is a protocol violation; the counter clears and nothing is performed.
  - cpu_req and dbg_req together with wait_cnt < MAX_WAIT: CPU wins and wait_cnt increments.
  - Address wrap is not the arbiter's concern; addresses pass through unmodified.

Decomposition:
- Package monitor_pkg holds:
  - MON_RAM_ADDR_W = 11 and MON_DATA_W = 8.
  - Grant encoding GNT_NONE = 0, GNT_CPU = 1, GNT_DBG = 2.
  - Default MAX_WAIT.
- No sub-module is warranted. Grant logic, wait counter, read pipeline and stall counter sit in one module of about 150 lines.

Test Plan:
- Idle debug port, CPU writes $55 to $0123, then reads it:
  - ram_we = 1 with addr $123 in the write cycle.
  - cpu_ready stays 1 throughout.
  - ram_rdata = $55 in the cycle after the read.
- CPU idle, debug reads $07FF containing $A5:
  - dbg_ack in cycle N.
  - dbg_rvalid = 1 and dbg_rdata = $A5 in N+2.
  - dbg_rdata is held afterwards.
- CPU requests every cycle, debug write $3C to $0010, MAX_WAIT = 4:
  - The debug write is acked on the 5th cycle of dbg_req.
  - cpu_ready = 0 in that cycle only.
  - cpu_stall_cnt = 1.
  - A later CPU read of $0010 returns $3C.
- Simultaneous requests with MAX_WAIT = 0:
  - Debug wins every cycle it requests.
  - cpu_ready = 0 exactly in those cycles.
- Four back-to-back debug reads of $0000-$0003 holding $00-$03:
  - Four consecutive rvalid pulses carrying $00, $01, $02, $03 in order.
- Reset low in the cycle after a debug read ack:
  - No rvalid pulse.
  - wait_cnt, dbg_rdata and cpu_stall_cnt are 0.
  - ram_we = 0 while reset is low.
